// File: rtl/uart_rx_pkg.sv
// Shared definitions for the UART receive path: FSM state encodings, default
// line settings and helpers for deriving divider/counter widths.
package uart_rx_pkg;

  typedef enum logic [2:0] {
    ST_IDLE  = 3'd0,
    ST_START = 3'd1,
    ST_DATA  = 3'd2,
    ST_STOP  = 3'd3,
    ST_BREAK = 3'd4
  } uart_state_e;

  localparam int DEF_CLK_FREQ   = 50_000_000;
  localparam int DEF_BAUD       = 9600;
  localparam int DEF_OVERSAMPLE = 16;
  localparam int DEF_DATA_BITS  = 8;
  localparam int SYNC_STAGES    = 2;

  // Clock cycles per oversample tick; truncation is intentional.
  function automatic int calc_div(input int clk_freq, input int baud, input int oversample);
    return clk_freq / (baud * oversample);
  endfunction

  // Width of a counter that must hold 0..n-1, never narrower than one bit.
  function automatic int cnt_width(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/uart_baud_tick.sv
// Oversample tick source: counts 0..DIV-1 and emits a one-cycle tick on wrap.
// restart forces the count back to 0 so a new frame starts phase-aligned.
module uart_baud_tick
  import uart_rx_pkg::*;
#(
  parameter int DIV = 325
) (
  input  logic clk,
  input  logic rst,
  input  logic en,
  input  logic restart,
  output logic tick
);

  localparam int CW = cnt_width(DIV);
  localparam logic [CW-1:0] LAST = CW'(DIV - 1);

  logic [CW-1:0] cnt_reg;
  logic [CW-1:0] cnt_next;

  always_comb begin
    cnt_next = cnt_reg;
    if (restart) begin
      cnt_next = '0;
    end else if (en) begin
      cnt_next = (cnt_reg == LAST) ? '0 : cnt_reg + CW'(1);
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      cnt_reg <= '0;
    end else begin
      cnt_reg <= cnt_next;
    end
  end

  // A restart cycle never ticks, so the first tick lands DIV cycles later.
  assign tick = en && !restart && (cnt_reg == LAST);

endmodule

// File: rtl/uart_rx.sv
// 8N1-style UART receiver: synchronises the serial line, oversamples each bit,
// and presents completed bytes on a valid/ready interface with error pulses.
module uart_rx
  import uart_rx_pkg::*;
#(
  parameter int CLK_FREQ   = DEF_CLK_FREQ,
  parameter int BAUD       = DEF_BAUD,
  parameter int OVERSAMPLE = DEF_OVERSAMPLE,
  parameter int DATA_BITS  = DEF_DATA_BITS
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 rx_in,
  output logic [DATA_BITS-1:0] rx_data,
  output logic                 rx_valid,
  input  logic                 rx_ready,
  output logic                 frame_err,
  output logic                 overrun,
  output logic                 busy
);

  localparam int DIV = calc_div(CLK_FREQ, BAUD, OVERSAMPLE);
  localparam int TW  = cnt_width(OVERSAMPLE);
  localparam int BW  = cnt_width(DATA_BITS);

  localparam logic [TW-1:0] HALF_LAST = TW'(OVERSAMPLE / 2 - 1);
  localparam logic [TW-1:0] FULL_LAST = TW'(OVERSAMPLE - 1);
  localparam logic [BW-1:0] LAST_BIT  = BW'(DATA_BITS - 1);

  // Synchroniser: both stages reset to the idle-high line level.
  logic [SYNC_STAGES-1:0] sync_reg;
  logic                   rxs;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      sync_reg <= '1;
    end else begin
      sync_reg <= {sync_reg[SYNC_STAGES-2:0], rx_in};
    end
  end

  assign rxs = sync_reg[SYNC_STAGES-1];

  uart_state_e state_reg;
  uart_state_e state_next;

  logic [TW-1:0]        tcnt_reg;
  logic [BW-1:0]        bitcnt_reg;
  logic [DATA_BITS-1:0] shreg_reg;
  logic [DATA_BITS-1:0] rx_data_reg;
  logic                 rx_valid_reg;
  logic                 frame_err_reg;
  logic                 overrun_reg;

  logic tick;
  logic tick_restart;
  logic tcnt_clr;
  logic tcnt_inc;
  logic bitcnt_clr;
  logic bit_sample;
  logic frame_done;
  logic frame_bad;

  uart_baud_tick #(
    .DIV(DIV)
  ) u_baud_tick (
    .clk    (clk),
    .rst    (rst),
    .en     (1'b1),
    .restart(tick_restart),
    .tick   (tick)
  );

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_reg <= ST_IDLE;
    end else begin
      state_reg <= state_next;
    end
  end

  always_comb begin
    state_next   = state_reg;
    tick_restart = 1'b0;
    tcnt_clr     = 1'b0;
    tcnt_inc     = 1'b0;
    bitcnt_clr   = 1'b0;
    bit_sample   = 1'b0;
    frame_done   = 1'b0;
    frame_bad    = 1'b0;

    case (state_reg)
      ST_IDLE: begin
        if (!rxs) begin
          state_next   = ST_START;
          tick_restart = 1'b1;
          tcnt_clr     = 1'b1;
        end
      end

      ST_START: begin
        if (tick) begin
          if (tcnt_reg == HALF_LAST) begin
            // A line back high at mid start bit was only a glitch.
            if (rxs) begin
              state_next = ST_IDLE;
            end else begin
              state_next = ST_DATA;
              tcnt_clr   = 1'b1;
              bitcnt_clr = 1'b1;
            end
          end else begin
            tcnt_inc = 1'b1;
          end
        end
      end

      ST_DATA: begin
        if (tick) begin
          if (tcnt_reg == FULL_LAST) begin
            bit_sample = 1'b1;
            tcnt_clr   = 1'b1;
            if (bitcnt_reg == LAST_BIT) begin
              state_next = ST_STOP;
            end
          end else begin
            tcnt_inc = 1'b1;
          end
        end
      end

      ST_STOP: begin
        if (tick) begin
          if (tcnt_reg == FULL_LAST) begin
            tcnt_clr = 1'b1;
            if (rxs) begin
              state_next = ST_IDLE;
              frame_done = 1'b1;
            end else begin
              state_next = ST_BREAK;
              frame_bad  = 1'b1;
            end
          end else begin
            tcnt_inc = 1'b1;
          end
        end
      end

      ST_BREAK: begin
        // Stay here for the whole low period so a held line reports once.
        if (rxs) begin
          state_next = ST_IDLE;
        end
      end

      default: begin
        state_next = ST_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      tcnt_reg   <= '0;
      bitcnt_reg <= '0;
      shreg_reg  <= '0;
    end else begin
      if (tcnt_clr) begin
        tcnt_reg <= '0;
      end else if (tcnt_inc) begin
        tcnt_reg <= tcnt_reg + TW'(1);
      end

      if (bitcnt_clr) begin
        bitcnt_reg <= '0;
      end else if (bit_sample) begin
        bitcnt_reg <= bitcnt_reg + BW'(1);
      end

      // LSB arrives first, so shifting in at the MSB leaves it at bit 0.
      if (bit_sample) begin
        shreg_reg <= {rxs, shreg_reg[DATA_BITS-1:1]};
      end
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      rx_data_reg   <= '0;
      rx_valid_reg  <= 1'b0;
      frame_err_reg <= 1'b0;
      overrun_reg   <= 1'b0;
    end else begin
      frame_err_reg <= frame_bad;
      overrun_reg   <= frame_done && rx_valid_reg && !rx_ready;

      // A completion wins over a same-cycle acceptance of the older byte.
      if (frame_done) begin
        rx_data_reg  <= shreg_reg;
        rx_valid_reg <= 1'b1;
      end else if (rx_valid_reg && rx_ready) begin
        rx_valid_reg <= 1'b0;
      end
    end
  end

  assign rx_data   = rx_data_reg;
  assign rx_valid  = rx_valid_reg;
  assign frame_err = frame_err_reg;
  assign overrun   = overrun_reg;
  assign busy      = (state_reg != ST_IDLE);

endmodule

// File: tb/tb_uart_rx.sv
// Self-checking bench for uart_rx: table of whole frames plus hand-written
// sequences for glitch, break, overrun, same-cycle accept and mid-frame reset.
`timescale 1ns/1ps
module tb_uart_rx;

  localparam int CLK_FREQ   = 1_600_000;
  localparam int BAUD       = 10_000;
  localparam int OVERSAMPLE = 16;
  localparam int DATA_BITS  = 8;
  localparam int BIT_CLK    = CLK_FREQ / BAUD;

  logic       clk = 1'b0;
  logic       rst = 1'b0;
  logic       rx_in = 1'b1;
  logic       rx_ready = 1'b0;
  logic [7:0] rx_data;
  logic       rx_valid;
  logic       frame_err;
  logic       overrun;
  logic       busy;

  int checks = 0;
  int errors = 0;
  int ferr_cnt = 0;
  int ovr_cnt = 0;
  logic [7:0] exp_q[$];

  typedef struct {
    logic [7:0] data;
    logic       stop_bit;
    logic       exp_valid;
    int         exp_ferr;
  } vec_t;

  vec_t vecs[6];

  always #5 clk = ~clk;

  uart_rx #(
    .CLK_FREQ  (CLK_FREQ),
    .BAUD      (BAUD),
    .OVERSAMPLE(OVERSAMPLE),
    .DATA_BITS (DATA_BITS)
  ) dut (
    .clk      (clk),
    .rst      (rst),
    .rx_in    (rx_in),
    .rx_data  (rx_data),
    .rx_valid (rx_valid),
    .rx_ready (rx_ready),
    .frame_err(frame_err),
    .overrun  (overrun),
    .busy     (busy)
  );

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  // Scoreboard: every accepted byte must match the oldest expected byte.
  always @(negedge clk) begin
    if (rst) begin
      if (frame_err) ferr_cnt++;
      if (overrun) ovr_cnt++;
      if (rx_valid && rx_ready) begin
        if (exp_q.size() == 0) begin
          checks++;
          errors++;
          $display("FAIL sb_empty: got 0x%02h expected no byte", rx_data);
        end else begin
          check("sb_data", {24'd0, rx_data}, {24'd0, exp_q.pop_front()});
        end
        $display("accepted byte 0x%02h", rx_data);
      end
    end
  end

  task automatic tick_clk(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic drive_bit(input logic b);
    rx_in = b;
    tick_clk(BIT_CLK);
  endtask

  task automatic send_data(input logic [7:0] d);
    drive_bit(1'b0);
    for (int i = 0; i < 8; i++) drive_bit(d[i]);
  endtask

  task automatic send_frame(input logic [7:0] d, input logic stop_bit);
    send_data(d);
    drive_bit(stop_bit);
    rx_in = 1'b1;
  endtask

  task automatic accept();
    rx_ready = 1'b1;
    tick_clk(1);
    rx_ready = 1'b0;
  endtask

  task automatic wait_valid(input int limit, output int cyc);
    cyc = 0;
    while (!rx_valid && cyc < limit) begin
      @(negedge clk);
      cyc++;
    end
  endtask

  initial begin
    int ferr0;
    int ovr0;
    int lat;
    int cyc;

    vecs[0] = '{8'h68, 1'b1, 1'b1, 0};
    vecs[1] = '{8'hA5, 1'b1, 1'b1, 0};
    vecs[2] = '{8'h00, 1'b1, 1'b1, 0};
    vecs[3] = '{8'hFF, 1'b1, 1'b1, 0};
    vecs[4] = '{8'h81, 1'b0, 1'b0, 1};
    vecs[5] = '{8'h7E, 1'b1, 1'b1, 0};

    // Reset state
    tick_clk(5);
    check("rst_data", rx_data, 0);
    check("rst_valid", rx_valid, 0);
    check("rst_ferr", frame_err, 0);
    check("rst_ovr", overrun, 0);
    check("rst_busy", busy, 0);
    rst = 1'b1;
    tick_clk(20);

    // Table of whole frames
    for (int v = 0; v < 6; v++) begin
      ferr0 = ferr_cnt;
      ovr0  = ovr_cnt;
      if (vecs[v].exp_valid) exp_q.push_back(vecs[v].data);
      send_frame(vecs[v].data, vecs[v].stop_bit);
      tick_clk(10);
      $display("vec %0d: sent 0x%02h stop=%0b valid=%0b ferr=%0d", v, vecs[v].data,
               vecs[v].stop_bit, rx_valid, ferr_cnt - ferr0);
      check("vec_valid", rx_valid, vecs[v].exp_valid);
      check("vec_ferr", ferr_cnt - ferr0, vecs[v].exp_ferr);
      check("vec_ovr", ovr_cnt - ovr0, 0);
      check("vec_busy", busy, 0);
      if (vecs[v].exp_valid) begin
        tick_clk(5);
        check("vec_hold", rx_valid, 1);
        accept();
        check("vec_drop", rx_valid, 0);
      end
    end

    // T1: latency and hold
    ferr0 = ferr_cnt;
    ovr0  = ovr_cnt;
    exp_q.push_back(8'h68);
    fork
      send_frame(8'h68, 1'b1);
      wait_valid(2000, lat);
      begin
        tick_clk(400);
        check("t1_busy_mid", busy, 1);
      end
    join
    checks++;
    if (lat < 1515 || lat > 1530) begin
      errors++;
      $display("FAIL t1_latency: got %0d cycles expected 1515..1530", lat);
    end
    $display("t1: byte 0x%02h valid after %0d cycles", rx_data, lat);
    check("t1_data", rx_data, 8'h68);
    tick_clk(30);
    check("t1_hold", rx_valid, 1);
    accept();
    check("t1_drop", rx_valid, 0);
    check("t1_ferr", ferr_cnt - ferr0, 0);
    check("t1_ovr", ovr_cnt - ovr0, 0);

    // T2: start-bit glitch
    ferr0 = ferr_cnt;
    rx_in = 1'b0;
    tick_clk(48);
    rx_in = 1'b1;
    cyc = 0;
    while (busy && cyc < 80) begin
      tick_clk(1);
      cyc++;
    end
    $display("t2: busy cleared %0d cycles after glitch end", cyc);
    check("t2_busy", busy, 0);
    tick_clk(200);
    check("t2_valid", rx_valid, 0);
    check("t2_ferr", ferr_cnt - ferr0, 0);

    // T3: break after 0x55, then clean 0xA3
    ferr0 = ferr_cnt;
    send_data(8'h55);
    rx_in = 1'b0;
    tick_clk(3 * BIT_CLK);
    rx_in = 1'b1;
    tick_clk(BIT_CLK);
    $display("t3: break gave %0d frame errors", ferr_cnt - ferr0);
    check("t3_ferr_once", ferr_cnt - ferr0, 1);
    check("t3_valid", rx_valid, 0);
    check("t3_busy", busy, 0);
    exp_q.push_back(8'hA3);
    send_frame(8'hA3, 1'b1);
    tick_clk(4);
    check("t3_valid2", rx_valid, 1);
    check("t3_data2", rx_data, 8'hA3);
    accept();

    // T4: back-to-back bytes, no acceptance -> overrun
    ovr0 = ovr_cnt;
    exp_q.push_back(8'hFF);
    send_frame(8'h00, 1'b1);
    send_frame(8'hFF, 1'b1);
    tick_clk(4);
    $display("t4: overruns=%0d data=0x%02h", ovr_cnt - ovr0, rx_data);
    check("t4_ovr", ovr_cnt - ovr0, 1);
    check("t4_valid", rx_valid, 1);
    check("t4_data", rx_data, 8'hFF);
    accept();

    // T5: acceptance in the exact completion cycle of the second byte
    ovr0 = ovr_cnt;
    exp_q.push_back(8'h11);
    exp_q.push_back(8'h22);
    send_frame(8'h11, 1'b1);
    fork
      send_frame(8'h22, 1'b1);
      begin
        tick_clk(1522);
        rx_ready = 1'b1;
        tick_clk(1);
        rx_ready = 1'b0;
      end
    join
    tick_clk(4);
    $display("t5: overruns=%0d valid=%0b data=0x%02h", ovr_cnt - ovr0, rx_valid, rx_data);
    check("t5_ovr", ovr_cnt - ovr0, 0);
    check("t5_valid", rx_valid, 1);
    check("t5_data", rx_data, 8'h22);
    accept();

    // T6: reset during data bit 4, then a clean frame
    send_frame(8'h5A, 1'b1);
    tick_clk(4);
    check("t6_pre_valid", rx_valid, 1);
    fork
      send_frame(8'h3C, 1'b1);
      begin
        tick_clk(BIT_CLK * 5 + 80);
        check("t6_pre_busy", busy, 1);
        rst = 1'b0;
        #1;
        check("t6_rst_data", rx_data, 0);
        check("t6_rst_valid", rx_valid, 0);
        check("t6_rst_busy", busy, 0);
        check("t6_rst_ferr", frame_err, 0);
        check("t6_rst_ovr", overrun, 0);
      end
    join
    tick_clk(10);
    rst = 1'b1;
    tick_clk(10);
    exp_q.push_back(8'h3C);
    send_frame(8'h3C, 1'b1);
    tick_clk(4);
    $display("t6: after reset received 0x%02h valid=%0b", rx_data, rx_valid);
    check("t6_valid", rx_valid, 1);
    check("t6_data", rx_data, 8'h3C);
    accept();
    tick_clk(4);

    check("sb_drained", exp_q.size(), 0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
